mux_cdc_launcher: RTL and testbench

Source-side launcher for the 4-bit clk_a→clk_b enable-qualified CDC crossing. Accepts words from a clk_a-domain producer over a valid/ready handshake and buffers them in a small FIFO. Each word is presented to the crossing as a level-held tx_data/tx_en burst: data stable for HOLD_CYCLES with tx_en high, then a GAP_CYCLES quiet gap with tx_en low. The destination synchroniser can therefore qualify every word on a multi-cycle-stable enable. It sits directly upstream of the crossing and drives its data_in/data_en inputs.

---
 rtl/mux_cdc_launcher.sv | 128 ++++++++++++
 tb/tb_mux_cdc_launcher.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_cdc_launcher.sv
// Source-side launcher for the clk_a->clk_b enable-qualified crossing: FIFO-buffered words
// are replayed as level-held tx_data/tx_en bursts separated by a quiet gap.
//
// state  | meaning
// S_IDLE | tx_en low, waiting for a buffered word; pops the head when one is present
// S_HOLD | tx_en high, tx_data frozen for HOLD_CYCLES cycles
// S_GAP  | tx_en low for GAP_CYCLES cycles, tx_data keeps the last word
module mux_cdc_launcher #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                     clk_a,
  input  logic                     arstn,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         tx_data,
  output logic                     tx_en,
  output logic                     tx_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = PW + 1;
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  tx_data_q;
  logic              tx_en_q;
  logic              tx_done_q;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;

  logic              push;
  logic              pop;

  assign in_ready = (level_q != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == S_IDLE) && (level_q != '0);

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (push) mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            tx_data_q <= mem_q[rd_ptr_q];
            tx_en_q   <= 1'b1;
            cnt_q     <= CW'(HOLD_CYCLES - 1);
            state_q   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            tx_en_q   <= 1'b0;
            tx_done_q <= 1'b1;
            cnt_q     <= CW'(GAP_CYCLES - 1);
            state_q   <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
          else             state_q <= S_IDLE;
        end
        default: begin
          tx_en_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_data = tx_data_q;
  assign tx_en   = tx_en_q;
  assign tx_done = tx_done_q;
  assign level   = level_q;
  assign busy    = (state_q != S_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_mux_cdc_launcher.sv
// Bench for mux_cdc_launcher: scoreboard of accepted words, burst-shape monitor, scenario tasks.
module tb_mux_cdc_launcher;
  localparam int HOLD = 8;
  localparam int GAP  = 4;

  logic       clk_a = 1'b0;
  logic       arstn = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] tx_data;
  logic       tx_en;
  logic       tx_done;
  logic       busy;
  logic [2:0] level;

  mux_cdc_launcher #(.WIDTH(4), .DEPTH(4), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk_a(clk_a), .arstn(arstn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_data(tx_data), .tx_en(tx_en), .tx_done(tx_done),
    .busy(busy), .level(level)
  );

  always #5 clk_a = ~clk_a;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  logic [3:0] exp_q[$];
  int rise_cyc[$];

  always @(posedge clk_a) cyc <= cyc + 1;

  // Burst-shape monitor: checks order, hold length, gap length, tx_done and data stability.
  logic       prev_en = 1'b0;
  logic [3:0] held = '0;
  logic [3:0] exp_w;
  int hold_cnt = 0;
  int gap_cnt = 100;

  always @(negedge clk_a) begin
    if (!arstn) begin
      prev_en = 1'b0; held = '0; hold_cnt = 0; gap_cnt = 100;
    end else begin
      if (tx_en && !prev_en) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL burst_unexpected: got tx_data=%h, required no burst", tx_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (tx_data !== exp_w) $display("FAIL burst_order: got tx_data=%h, required %h", tx_data, exp_w);
          else n_pass++;
        end
        n_total++;
        if (gap_cnt < GAP) $display("FAIL gap_len: got %0d low cycles, required >=%0d", gap_cnt, GAP);
        else n_pass++;
        held = tx_data; hold_cnt = 1; rise_cyc.push_back(cyc);
      end else if (tx_en) begin
        hold_cnt++;
        n_total++;
        if (tx_data !== held || tx_done !== 1'b0)
          $display("FAIL hold_stable: got data=%h done=%b, required data=%h done=0", tx_data, tx_done, held);
        else n_pass++;
      end else if (prev_en) begin
        n_total++;
        if (hold_cnt != HOLD || tx_done !== 1'b1 || tx_data !== held)
          $display("FAIL burst_end: got hold=%0d done=%b data=%h, required hold=%0d done=1 data=%h",
                   hold_cnt, tx_done, tx_data, HOLD, held);
        else n_pass++;
        gap_cnt = 1;
      end else begin
        gap_cnt++;
        n_total++;
        if (tx_data !== held || tx_done !== 1'b0)
          $display("FAIL low_stable: got data=%h done=%b, required data=%h done=0", tx_data, tx_done, held);
        else n_pass++;
      end
      prev_en = tx_en;
    end
  end

  task automatic tick();
    @(posedge clk_a); #1;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy && !tx_en) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if ({tx_en, tx_data, level, busy, tx_done, in_ready} !== {1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_state: got en=%b data=%h level=%0d busy=%b done=%b ready=%b, required 0 0 0 0 0 1",
               tx_en, tx_data, level, busy, tx_done, in_ready);
    else n_pass++;
    @(negedge clk_a); #2 arstn = 1'b1;
    tick();
    n_total++;
    if (in_ready !== 1'b1 || level !== 3'd0 || busy !== 1'b0)
      $display("FAIL reset_release: got ready=%b level=%0d busy=%b, required 1 0 0", in_ready, level, busy);
    else n_pass++;
  endtask

  task automatic test_single();
    int n0, done_cnt;
    n0 = rise_cyc.size();
    @(negedge clk_a); in_data = 4'hA; in_valid = 1'b1; exp_q.push_back(4'hA);
    tick();
    in_valid = 1'b0;
    n_total++;
    if (level !== 3'd1 || tx_en !== 1'b0)
      $display("FAIL single_accept: got level=%0d en=%b, required 1 0", level, tx_en);
    else n_pass++;
    tick();
    n_total++;
    if (tx_en !== 1'b1 || tx_data !== 4'hA)
      $display("FAIL single_launch: got en=%b data=%h, required 1 a", tx_en, tx_data);
    else n_pass++;
    done_cnt = 0;
    for (int i = 2; i <= 12; i++) begin
      tick();
      if (tx_done === 1'b1) done_cnt++;
    end
    n_total++;
    if (done_cnt != 1) $display("FAIL single_done: got %0d pulses, required 1", done_cnt);
    else n_pass++;
    n_total++;
    if (busy !== 1'b1 || tx_en !== 1'b0)
      $display("FAIL single_gap_busy: got busy=%b en=%b, required 1 0", busy, tx_en);
    else n_pass++;
    tick();
    n_total++;
    if (busy !== 1'b0 || level !== 3'd0)
      $display("FAIL single_idle: got busy=%b level=%0d, required 0 0", busy, level);
    else n_pass++;
    n_total++;
    if (rise_cyc.size() - n0 != 1) $display("FAIL single_bursts: got %0d, required 1", rise_cyc.size() - n0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n0;
    bit ok;
    n0 = rise_cyc.size();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_a); in_data = 4'(i + 1); in_valid = 1'b1; exp_q.push_back(4'(i + 1));
    end
    @(negedge clk_a); in_valid = 1'b0;
    tick();
    wait_idle(80, ok);
    n_total++;
    if (!ok) $display("FAIL b2b_timeout: got busy=%b, required 0 within 80 cycles", busy);
    else n_pass++;
    n_total++;
    if (rise_cyc.size() - n0 != 3) $display("FAIL b2b_bursts: got %0d, required 3", rise_cyc.size() - n0);
    else begin
      n_pass++;
      n_total++;
      if (rise_cyc[n0+1] - rise_cyc[n0] != 13 || rise_cyc[n0+2] - rise_cyc[n0+1] != 13)
        $display("FAIL b2b_spacing: got %0d,%0d, required 13,13",
                 rise_cyc[n0+1] - rise_cyc[n0], rise_cyc[n0+2] - rise_cyc[n0+1]);
      else n_pass++;
    end
    n_total++;
    if (exp_q.size() != 0) $display("FAIL b2b_drain: got %0d words left, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_full();
    int n0, accepted;
    bit ok;
    n0 = rise_cyc.size();
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_a); in_data = 4'(4 + i); in_valid = 1'b1;
      if (i == 5) begin
        n_total++;
        if (in_ready !== 1'b0 || level !== 3'd4)
          $display("FAIL full_ready: got ready=%b level=%0d, required 0 4", in_ready, level);
        else n_pass++;
      end
      if (in_ready) begin exp_q.push_back(4'(4 + i)); accepted++; end
    end
    @(negedge clk_a); in_valid = 1'b0;
    n_total++;
    if (accepted != 5) $display("FAIL full_accepted: got %0d, required 5", accepted);
    else n_pass++;
    tick();
    wait_idle(120, ok);
    n_total++;
    if (!ok) $display("FAIL full_timeout: got busy=%b, required 0 within 120 cycles", busy);
    else n_pass++;
    n_total++;
    if (rise_cyc.size() - n0 != 5 || exp_q.size() != 0)
      $display("FAIL full_bursts: got %0d bursts %0d left, required 5 0", rise_cyc.size() - n0, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_simul();
    int n0;
    bit ok;
    n0 = rise_cyc.size();
    @(negedge clk_a); in_data = 4'hB; in_valid = 1'b1; exp_q.push_back(4'hB);
    tick();
    n_total++;
    if (level !== 3'd1 || tx_en !== 1'b0 || busy !== 1'b1)
      $display("FAIL simul_pre: got level=%0d en=%b busy=%b, required 1 0 1", level, tx_en, busy);
    else n_pass++;
    @(negedge clk_a); in_data = 4'hC; exp_q.push_back(4'hC);
    tick();
    in_valid = 1'b0;
    n_total++;
    if (level !== 3'd1 || tx_en !== 1'b1 || tx_data !== 4'hB)
      $display("FAIL simul_pushpop: got level=%0d en=%b data=%h, required 1 1 b", level, tx_en, tx_data);
    else n_pass++;
    wait_idle(60, ok);
    n_total++;
    if (!ok || rise_cyc.size() - n0 != 2 || exp_q.size() != 0)
      $display("FAIL simul_drain: got ok=%b bursts=%0d left=%0d, required 1 2 0", ok, rise_cyc.size() - n0, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_hold();
    int n0, n1;
    n0 = rise_cyc.size();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_a); in_data = 4'(5 + i); in_valid = 1'b1; exp_q.push_back(4'(5 + i));
    end
    @(negedge clk_a); in_valid = 1'b0;
    @(negedge clk_a);
    n_total++;
    if (tx_en !== 1'b1 || tx_data !== 4'h5)
      $display("FAIL midhold_pre: got en=%b data=%h, required 1 5", tx_en, tx_data);
    else n_pass++;
    #2 arstn = 1'b0;
    #1;
    n_total++;
    if ({tx_en, tx_data, level, busy, tx_done, in_ready} !== {1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL midhold_reset: got en=%b data=%h level=%0d busy=%b done=%b ready=%b, required 0 0 0 0 0 1",
               tx_en, tx_data, level, busy, tx_done, in_ready);
    else n_pass++;
    exp_q.delete();
    repeat (2) @(negedge clk_a);
    #2 arstn = 1'b1;
    n1 = rise_cyc.size();
    n_total++;
    if (n1 - n0 != 1) $display("FAIL midhold_first: got %0d bursts, required 1", n1 - n0);
    else n_pass++;
    repeat (40) tick();
    n_total++;
    if (rise_cyc.size() != n1 || tx_en !== 1'b0 || busy !== 1'b0 || level !== 3'd0)
      $display("FAIL midhold_quiet: got bursts=%0d en=%b busy=%b level=%0d, required 0 0 0 0",
               rise_cyc.size() - n1, tx_en, busy, level);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_simul();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time 200000, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
